// File: rtl/lock_keypad.sv
// lock_keypad: keypad command stage ahead of the lock FSM.
// Collects digits, checks them against CODE on enter, and issues
// one-cycle open/close commands. Repeated failures start a lockout
// window. A successful open arms an automatic close timer.
module lock_keypad #(
    parameter int                             CODE_LEN          = 4,
    parameter int                             DIGIT_W           = 4,
    parameter logic [CODE_LEN*DIGIT_W-1:0]    CODE              = 16'h1234,
    parameter int                             MAX_FAIL          = 3,
    parameter int                             LOCKOUT_CYCLES    = 16,
    parameter int                             AUTO_CLOSE_CYCLES = 32
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               digit_valid,
    input  logic [DIGIT_W-1:0]                 digit,
    input  logic                               enter,
    input  logic                               close_req,
    output logic                               open,
    output logic                               close,
    output logic                               locked_out,
    output logic [$clog2(MAX_FAIL+1)-1:0]      fail_count
);

    localparam int BW = CODE_LEN * DIGIT_W;
    localparam int CW = $clog2(CODE_LEN + 1);
    localparam int FW = $clog2(MAX_FAIL + 1);
    localparam int LW = $clog2(LOCKOUT_CYCLES + 1);
    localparam int AW = $clog2(AUTO_CLOSE_CYCLES + 1);

    localparam logic [CW-1:0] CODE_LEN_W = CW'(CODE_LEN);
    localparam logic [FW-1:0] MAX_FAIL_W = FW'(MAX_FAIL);
    localparam logic [LW-1:0] LOCK_LAST  = LW'(LOCKOUT_CYCLES - 1);
    localparam logic [AW-1:0] AC_LAST    = AW'(AUTO_CLOSE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        ENTRY,
        LOCKOUT
    } state_t;

    state_t          state;
    logic [BW-1:0]   entry_buf;
    logic [CW-1:0]   count;
    logic            ovf;
    logic [LW-1:0]   lock_cnt;
    logic            ac_active;
    logic [AW-1:0]   ac_cnt;

    logic            accept;
    logic            do_enter;
    logic            do_digit;
    logic            match;
    logic            do_open;
    logic [FW-1:0]   fail_nxt;

    // Decode this cycle's keypad action; enter beats a same-cycle digit.
    always_comb begin
        accept   = (state != LOCKOUT);
        do_enter = accept && enter;
        do_digit = accept && digit_valid && !enter;
        match    = (count == CODE_LEN_W) && !ovf && (entry_buf == CODE);
        // A simultaneous close request suppresses the open so the two
        // commands never collide.
        do_open  = do_enter && match && !close_req;
        fail_nxt = fail_count + 1'b1;
    end

    // Entry/lockout state machine: buffer, fail counting, open pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            entry_buf  <= '0;
            count      <= '0;
            ovf        <= 1'b0;
            fail_count <= '0;
            locked_out <= 1'b0;
            lock_cnt   <= '0;
            open       <= 1'b0;
        end else begin
            open <= do_open;
            case (state)
                IDLE, ENTRY: begin
                    if (do_enter) begin
                        entry_buf <= '0;
                        count     <= '0;
                        ovf       <= 1'b0;
                        state     <= IDLE;
                        if (match) begin
                            // Matching code pre-empted by close_req keeps fail_count.
                            if (!close_req) fail_count <= '0;
                        end else begin
                            fail_count <= fail_nxt;
                            if (fail_nxt == MAX_FAIL_W) begin
                                state      <= LOCKOUT;
                                locked_out <= 1'b1;
                                lock_cnt   <= LOCK_LAST;
                            end
                        end
                    end else if (do_digit) begin
                        // Newest digit enters at the LSB so the first digit
                        // ends up aligned with the code's MSB digit.
                        entry_buf <= (entry_buf << DIGIT_W) | BW'(digit);
                        if (count == CODE_LEN_W) ovf <= 1'b1;
                        else                     count <= count + 1'b1;
                        state <= ENTRY;
                    end
                end
                LOCKOUT: begin
                    if (lock_cnt == '0) begin
                        locked_out <= 1'b0;
                        fail_count <= '0;
                        state      <= IDLE;
                    end else begin
                        lock_cnt <= lock_cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Close command: manual request or auto-close timer expiry.
    always_ff @(posedge clk) begin
        if (reset) begin
            ac_active <= 1'b0;
            ac_cnt    <= '0;
            close     <= 1'b0;
        end else begin
            close <= 1'b0;
            if (do_open) begin
                // Fresh open restarts the timer even if one was running.
                ac_active <= 1'b1;
                ac_cnt    <= AC_LAST;
            end else if (close_req) begin
                ac_active <= 1'b0;
                close     <= 1'b1;
            end else if (ac_active) begin
                if (ac_cnt == '0) begin
                    ac_active <= 1'b0;
                    close     <= 1'b1;
                end else begin
                    ac_cnt <= ac_cnt - 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_lock_keypad.sv
// Directed testbench for lock_keypad with default parameters
// (CODE=1234, MAX_FAIL=3, LOCKOUT_CYCLES=16, AUTO_CLOSE_CYCLES=32).
module tb_lock_keypad;

    logic       clk;
    logic       reset;
    logic       digit_valid;
    logic [3:0] digit;
    logic       enter;
    logic       close_req;
    logic       open;
    logic       close;
    logic       locked_out;
    logic [1:0] fail_count;

    int errors;
    int checks;

    lock_keypad dut (
        .clk         (clk),
        .reset       (reset),
        .digit_valid (digit_valid),
        .digit       (digit),
        .enter       (enter),
        .close_req   (close_req),
        .open        (open),
        .close       (close),
        .locked_out  (locked_out),
        .fail_count  (fail_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge; outputs are sampled 1ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] d);
        digit_valid = 1'b1;
        digit       = d;
        tick();
        digit_valid = 1'b0;
        digit       = 4'h0;
    endtask

    task automatic press_enter();
        enter = 1'b1;
        tick();
        enter = 1'b0;
    endtask

    task automatic enter_code(input logic [3:0] a, input logic [3:0] b,
                              input logic [3:0] c, input logic [3:0] d);
        press(a); press(b); press(c); press(d);
        press_enter();
    endtask

    task automatic pulse_close();
        close_req = 1'b1;
        tick();
        close_req = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        checks++;
        if (open !== 1'b0) begin errors++; $display("FAIL reset_open got=%b exp=0", open); end
        checks++;
        if (close !== 1'b0) begin errors++; $display("FAIL reset_close got=%b exp=0", close); end
        checks++;
        if (locked_out !== 1'b0) begin errors++; $display("FAIL reset_locked got=%b exp=0", locked_out); end
        checks++;
        if (fail_count !== 2'd0) begin errors++; $display("FAIL reset_fail got=%0d exp=0", fail_count); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_open_autoclose();
        enter_code(4'h1, 4'h2, 4'h3, 4'h4);
        checks++;
        if (open !== 1'b1) begin errors++; $display("FAIL good_open got=%b exp=1", open); end
        checks++;
        if (fail_count !== 2'd0) begin errors++; $display("FAIL good_fail got=%0d exp=0", fail_count); end
        checks++;
        if (close !== 1'b0) begin errors++; $display("FAIL good_close0 got=%b exp=0", close); end
        for (int i = 1; i <= 33; i++) begin
            tick();
            checks++;
            if (close !== (i == 32) || open !== 1'b0) begin
                errors++;
                $display("FAIL autoclose_cyc%0d close=%b open=%b exp close=%b open=0",
                         i, close, open, (i == 32));
            end
        end
    endtask

    task automatic test_lockout();
        for (int a = 1; a <= 3; a++) begin
            enter_code(4'h1, 4'h2, 4'h3, 4'h5);
            checks++;
            if (open !== 1'b0 || fail_count !== 2'(a) || locked_out !== (a == 3)) begin
                errors++;
                $display("FAIL bad_attempt%0d open=%b fail=%0d locked=%b exp open=0 fail=%0d locked=%b",
                         a, open, fail_count, locked_out, a, (a == 3));
            end
        end
        // Cycle 1 of lockout already observed; cycles 2..16 follow with keypad noise.
        for (int i = 2; i <= 16; i++) begin
            if (i >= 2 && i <= 5) begin
                digit_valid = 1'b1;
                digit       = 4'(i - 1);
            end
            if (i == 6) enter = 1'b1;
            tick();
            digit_valid = 1'b0;
            enter       = 1'b0;
            checks++;
            if (locked_out !== 1'b1 || open !== 1'b0 || fail_count !== 2'd3) begin
                errors++;
                $display("FAIL lockout_cyc%0d locked=%b open=%b fail=%0d exp locked=1 open=0 fail=3",
                         i, locked_out, open, fail_count);
            end
        end
        tick();
        checks++;
        if (locked_out !== 1'b0 || fail_count !== 2'd0) begin
            errors++;
            $display("FAIL lockout_end locked=%b fail=%0d exp locked=0 fail=0", locked_out, fail_count);
        end
    endtask

    task automatic test_overflow();
        press(4'h1); press(4'h2); press(4'h3); press(4'h4); press(4'h4);
        press_enter();
        checks++;
        if (open !== 1'b0 || fail_count !== 2'd1) begin
            errors++;
            $display("FAIL overflow open=%b fail=%0d exp open=0 fail=1", open, fail_count);
        end
        enter_code(4'h1, 4'h2, 4'h3, 4'h4);
        checks++;
        if (open !== 1'b1 || fail_count !== 2'd0) begin
            errors++;
            $display("FAIL after_overflow open=%b fail=%0d exp open=1 fail=0", open, fail_count);
        end
        pulse_close();
        checks++;
        if (close !== 1'b1) begin errors++; $display("FAIL ovf_close got=%b exp=1", close); end
    endtask

    task automatic test_close_wins();
        enter_code(4'h9, 4'h9, 4'h9, 4'h9);
        checks++;
        if (fail_count !== 2'd1) begin errors++; $display("FAIL cw_prefail got=%0d exp=1", fail_count); end
        press(4'h1); press(4'h2); press(4'h3); press(4'h4);
        enter     = 1'b1;
        close_req = 1'b1;
        tick();
        enter     = 1'b0;
        close_req = 1'b0;
        checks++;
        if (close !== 1'b1 || open !== 1'b0 || fail_count !== 2'd1) begin
            errors++;
            $display("FAIL close_wins close=%b open=%b fail=%0d exp close=1 open=0 fail=1",
                     close, open, fail_count);
        end
        for (int i = 1; i <= 40; i++) begin
            tick();
            checks++;
            if (close !== 1'b0 || open !== 1'b0) begin
                errors++;
                $display("FAIL cw_quiet_cyc%0d close=%b open=%b exp 0 0", i, close, open);
            end
        end
        // Entry was cleared, so a bare enter is a mismatch.
        press_enter();
        checks++;
        if (open !== 1'b0 || fail_count !== 2'd2) begin
            errors++;
            $display("FAIL cw_cleared open=%b fail=%0d exp open=0 fail=2", open, fail_count);
        end
        enter_code(4'h1, 4'h2, 4'h3, 4'h4);
        checks++;
        if (open !== 1'b1 || fail_count !== 2'd0) begin
            errors++;
            $display("FAIL cw_reopen open=%b fail=%0d exp open=1 fail=0", open, fail_count);
        end
        pulse_close();
    endtask

    task automatic test_manual_close();
        enter_code(4'h1, 4'h2, 4'h3, 4'h4);
        checks++;
        if (open !== 1'b1) begin errors++; $display("FAIL mc_open got=%b exp=1", open); end
        for (int i = 1; i <= 40; i++) begin
            if (i == 5) close_req = 1'b1;
            tick();
            close_req = 1'b0;
            checks++;
            if (close !== (i == 5) || open !== 1'b0) begin
                errors++;
                $display("FAIL manual_close_cyc%0d close=%b open=%b exp close=%b open=0",
                         i, close, open, (i == 5));
            end
        end
    endtask

    task automatic test_reset_in_lockout();
        for (int a = 1; a <= 3; a++) enter_code(4'h0, 4'h0, 4'h0, 4'h0);
        checks++;
        if (locked_out !== 1'b1) begin errors++; $display("FAIL rl_locked got=%b exp=1", locked_out); end
        for (int i = 2; i <= 7; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (locked_out !== 1'b0 || fail_count !== 2'd0) begin
            errors++;
            $display("FAIL reset_lockout locked=%b fail=%0d exp locked=0 fail=0", locked_out, fail_count);
        end
        enter_code(4'h1, 4'h2, 4'h3, 4'h4);
        checks++;
        if (open !== 1'b1 || close !== 1'b0) begin
            errors++;
            $display("FAIL rl_open open=%b close=%b exp open=1 close=0", open, close);
        end
    endtask

    initial begin
        errors      = 0;
        checks      = 0;
        reset       = 1'b1;
        digit_valid = 1'b0;
        digit       = 4'h0;
        enter       = 1'b0;
        close_req   = 1'b0;
        test_reset();
        test_open_autoclose();
        test_lockout();
        test_overflow();
        test_close_wins();
        test_manual_close();
        test_reset_in_lockout();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
